// File: rtl/radix8_ntt_scheduler.sv
// radix8_ntt_scheduler
// Sequences an in-place N-point NTT/INTT (N = 8**STAGES) over a banked
// coefficient memory. The scheduler issues one 8-point group read per cycle,
// then runs DP_LAT drain cycles so that a stage's last write lands before the
// next stage reads. Each write-back address is the read address delayed by
// exactly DP_LAT cycles.
module radix8_ntt_scheduler #(
    parameter int          STAGES = 2,
    parameter int          ADDR_W = 6,
    parameter int          DP_LAT = 2,
    parameter logic [1:0]  SEL_R8 = 2'b10,
    localparam int         STG_W  = (STAGES > 1) ? $clog2(STAGES) : 1,
    localparam int         GRP_W  = ADDR_W - 3,
    localparam int         TW_W   = GRP_W + STG_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  intt,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_valid,
    output logic [8*ADDR_W-1:0]   rd_addr,
    output logic [TW_W-1:0]       tw_addr,
    output logic [1:0]            select_mode,
    output logic                  ntt_intt_mode,
    output logic                  wr_valid,
    output logic [8*ADDR_W-1:0]   wr_addr
);

    localparam int DRN_W = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [STG_W-1:0]    step_q, step_d;
    logic [GRP_W-1:0]    grp_q, grp_d;
    logic [DRN_W-1:0]    drn_q, drn_d;
    logic                intt_q, intt_d;

    logic [STG_W-1:0]    stage_idx;
    logic [7:0]          shamt;
    logic [ADDR_W-1:0]   g_ext;
    logic [ADDR_W-1:0]   stride;
    logic [ADDR_W-1:0]   base;
    logic [8*ADDR_W-1:0] grp_addr;

    logic                dl_valid_q [DP_LAT];
    logic                dl_valid_d [DP_LAT];
    logic [8*ADDR_W-1:0] dl_addr_q  [DP_LAT];
    logic [8*ADDR_W-1:0] dl_addr_d  [DP_LAT];

    // Actual stage index: step counter runs forward, INTT walks stages in reverse
    always_comb begin
        stage_idx = intt_q ? (STG_W'(STAGES - 1) - step_q) : step_q;
    end

    // Group addressing; stride is a power of 8, so div/mod reduce to shift/mask
    always_comb begin
        shamt    = 8'(3 * (STAGES - 1 - int'(stage_idx)));
        g_ext    = ADDR_W'(grp_q);
        stride   = ADDR_W'(1) << shamt;
        base     = ((g_ext >> shamt) << (shamt + 8'd3)) | (g_ext & (stride - ADDR_W'(1)));
        grp_addr = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            grp_addr[k*ADDR_W +: ADDR_W] = base + (ADDR_W'(k) << shamt);
        end
    end

    // Next-state logic and issue-side outputs
    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        grp_d         = grp_q;
        drn_d         = drn_q;
        intt_d        = intt_q;
        busy          = 1'b0;
        done          = 1'b0;
        rd_valid      = 1'b0;
        rd_addr       = '0;
        tw_addr       = '0;
        select_mode   = 2'b00;
        ntt_intt_mode = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    intt_d  = intt;
                    step_d  = '0;
                    grp_d   = '0;
                    drn_d   = '0;
                end
            end
            S_ISSUE: begin
                rd_valid = mem_ready;
                rd_addr  = grp_addr;
                tw_addr  = {stage_idx, grp_q};
                if (mem_ready) begin
                    if (grp_q == '1) begin
                        grp_d   = '0;
                        drn_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        grp_d = grp_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (drn_q == DRN_W'(DP_LAT - 1)) begin
                    drn_d = '0;
                    if (step_q == STG_W'(STAGES - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        step_d  = step_q + 1'b1;
                        state_d = S_ISSUE;
                    end
                end else begin
                    drn_d = drn_q + 1'b1;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_q != S_IDLE) begin
            busy          = 1'b1;
            select_mode   = SEL_R8;
            ntt_intt_mode = intt_q;
        end
    end

    // Write-back delay line: shifts every cycle regardless of mem_ready
    always_comb begin
        dl_valid_d[0] = rd_valid;
        dl_addr_d[0]  = rd_addr;
        for (int unsigned i = 1; i < DP_LAT; i++) begin
            dl_valid_d[i] = dl_valid_q[i-1];
            dl_addr_d[i]  = dl_addr_q[i-1];
        end
    end

    assign wr_valid = dl_valid_q[DP_LAT-1];
    assign wr_addr  = dl_addr_q[DP_LAT-1];

    // State, counters and delay line; reset drops any in-flight writes
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            grp_q   <= '0;
            drn_q   <= '0;
            intt_q  <= 1'b0;
            for (int unsigned i = 0; i < DP_LAT; i++) begin
                dl_valid_q[i] <= 1'b0;
                dl_addr_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            grp_q   <= grp_d;
            drn_q   <= drn_d;
            intt_q  <= intt_d;
            for (int unsigned i = 0; i < DP_LAT; i++) begin
                dl_valid_q[i] <= dl_valid_d[i];
                dl_addr_q[i]  <= dl_addr_d[i];
            end
        end
    end

endmodule

// File: tb/tb_radix8_ntt_scheduler.sv
// Self-checking bench for radix8_ntt_scheduler (STAGES=2, ADDR_W=6, DP_LAT=2).
module tb_radix8_ntt_scheduler;

    localparam int ADDR_W = 6;
    localparam int TW_W   = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                intt;
    logic                mem_ready;
    logic                busy;
    logic                done;
    logic                rd_valid;
    logic [8*ADDR_W-1:0] rd_addr;
    logic [TW_W-1:0]     tw_addr;
    logic [1:0]          select_mode;
    logic                ntt_intt_mode;
    logic                wr_valid;
    logic [8*ADDR_W-1:0] wr_addr;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [8*ADDR_W-1:0] addr;
        int                  due;
    } wr_exp_t;

    wr_exp_t sb[$];

    radix8_ntt_scheduler #(
        .STAGES (2),
        .ADDR_W (6),
        .DP_LAT (2),
        .SEL_R8 (2'b10)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .intt          (intt),
        .mem_ready     (mem_ready),
        .busy          (busy),
        .done          (done),
        .rd_valid      (rd_valid),
        .rd_addr       (rd_addr),
        .tw_addr       (tw_addr),
        .select_mode   (select_mode),
        .ntt_intt_mode (ntt_intt_mode),
        .wr_valid      (wr_valid),
        .wr_addr       (wr_addr)
    );

    always #5 clk = ~clk;

    // Reference addresses straight from the stride/base formula
    function automatic logic [8*ADDR_W-1:0] exp_addr(input int s, input int g);
        int stride;
        int base;
        logic [8*ADDR_W-1:0] r;
        stride = 1;
        for (int i = 0; i < (1 - s); i++) stride = stride * 8;
        base = (g / stride) * stride * 8 + (g % stride);
        r = '0;
        for (int k = 0; k < 8; k++) r[k*ADDR_W +: ADDR_W] = ADDR_W'(base + k * stride);
        return r;
    endfunction

    function automatic logic [TW_W-1:0] exp_tw(input int s, input int g);
        return TW_W'(s * 8 + g);
    endfunction

    // One full transform, checked cycle by cycle; returns inside the done cycle
    task automatic run_transform(input string tag, input logic intt_m, input int st_a,
                                 input int st_n, input bit poke);
        int      stalls;
        int      e;
        int      pos;
        int      pass_i;
        int      s;
        int      writes;
        bit      exp_issue;
        bit      exp_rv;
        bit      exp_wv;
        bit      finished;
        wr_exp_t w;
        stalls   = 0;
        writes   = 0;
        finished = 1'b0;
        sb.delete();
        start     = 1'b1;
        intt      = intt_m;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 40 && !finished; c++) begin
            mem_ready = !(c >= st_a && c < st_a + st_n);
            if (poke) begin
                start = (c == 4);
                intt  = (c == 6) ? ~intt_m : intt_m;
            end
            #1;
            e         = c - stalls;
            pos       = (e - 1) % 10;
            pass_i    = (e - 1) / 10;
            exp_issue = (pass_i < 2) && (pos < 8);
            exp_rv    = exp_issue && mem_ready;
            s         = intt_m ? (1 - pass_i) : pass_i;

            n_checks++;
            if (rd_valid !== exp_rv) $display("FAIL %s rd_valid T+%0d: got %b expected %b", tag, c, rd_valid, exp_rv);
            else n_pass++;
            if (exp_issue) begin
                n_checks++;
                if (rd_addr !== exp_addr(s, pos)) $display("FAIL %s rd_addr T+%0d: got %h expected %h", tag, c, rd_addr, exp_addr(s, pos));
                else n_pass++;
                n_checks++;
                if (tw_addr !== exp_tw(s, pos)) $display("FAIL %s tw_addr T+%0d: got %h expected %h", tag, c, tw_addr, exp_tw(s, pos));
                else n_pass++;
            end
            if (exp_rv) begin
                w.addr = exp_addr(s, pos);
                w.due  = c + 2;
                sb.push_back(w);
            end else if (exp_issue) begin
                stalls++;
            end

            exp_wv = (sb.size() > 0) && (sb[0].due == c);
            n_checks++;
            if (wr_valid !== exp_wv) $display("FAIL %s wr_valid T+%0d: got %b expected %b", tag, c, wr_valid, exp_wv);
            else n_pass++;
            if (exp_wv) begin
                w = sb.pop_front();
                n_checks++;
                if (wr_addr !== w.addr) $display("FAIL %s wr_addr T+%0d: got %h expected %h", tag, c, wr_addr, w.addr);
                else n_pass++;
            end
            if (wr_valid === 1'b1) writes++;

            n_checks++;
            if ({busy, select_mode, ntt_intt_mode} !== {1'b1, 2'b10, intt_m})
                $display("FAIL %s busy/mode T+%0d: got %b%b%b expected 1_10_%b", tag, c, busy, select_mode, ntt_intt_mode, intt_m);
            else n_pass++;
            n_checks++;
            if (done !== (e == 21)) $display("FAIL %s done T+%0d: got %b expected %b", tag, c, done, (e == 21));
            else n_pass++;

            if (e == 21) finished = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        n_checks++;
        if (!finished) $display("FAIL %s timeout: done not reached within 40 cycles", tag);
        else n_pass++;
        n_checks++;
        if (writes != 16) $display("FAIL %s write_count: got %0d expected 16", tag, writes);
        else n_pass++;
        n_checks++;
        if (sb.size() != 0) $display("FAIL %s pending_writes: got %0d expected 0", tag, sb.size());
        else n_pass++;
        start     = 1'b0;
        intt      = intt_m;
        mem_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; intt = 1'b0; mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0; #1;
        n_checks++;
        if ({busy, done, rd_valid, wr_valid, ntt_intt_mode, select_mode} !== 7'b0)
            $display("FAIL reset_ctrl: got %b expected 0000000", {busy, done, rd_valid, wr_valid, ntt_intt_mode, select_mode});
        else n_pass++;
        n_checks++;
        if ({rd_addr, wr_addr, tw_addr} !== '0) $display("FAIL reset_addr: got %h %h %h expected 0", rd_addr, wr_addr, tw_addr);
        else n_pass++;

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({busy, rd_valid} !== 2'b11) $display("FAIL midrun_issue: got busy=%b rd_valid=%b expected 1 1", busy, rd_valid);
        else n_pass++;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0; #1;
        n_checks++;
        if ({busy, rd_valid, wr_valid, done} !== 4'b0)
            $display("FAIL midrun_reset: got busy=%b rd_valid=%b wr_valid=%b done=%b expected 0", busy, rd_valid, wr_valid, done);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({busy, wr_valid} !== 2'b00) $display("FAIL post_reset_idle cycle %0d: got busy=%b wr_valid=%b expected 0 0", i, busy, wr_valid);
            else n_pass++;
        end
    endtask

    task automatic test_ntt();
        run_transform("ntt", 1'b0, 0, 0, 1'b0);
        @(posedge clk); #1;
        n_checks++;
        if ({busy, done} !== 2'b00) $display("FAIL ntt_idle: got busy=%b done=%b expected 0 0", busy, done);
        else n_pass++;
    endtask

    task automatic test_intt();
        run_transform("intt", 1'b1, 0, 0, 1'b0);
        @(posedge clk); #1;
        n_checks++;
        if ({busy, ntt_intt_mode} !== 2'b00) $display("FAIL intt_idle: got busy=%b mode=%b expected 0 0", busy, ntt_intt_mode);
        else n_pass++;
    endtask

    task automatic test_stall();
        run_transform("stall", 1'b0, 3, 2, 1'b0);
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL stall_idle: got busy=%b expected 0", busy);
        else n_pass++;
    endtask

    task automatic test_ignore_start();
        run_transform("ignore", 1'b0, 0, 0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({busy, rd_valid} !== 2'b00) $display("FAIL ignore_no_restart cycle %0d: got busy=%b rd_valid=%b expected 0 0", i, busy, rd_valid);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        run_transform("b2b_first", 1'b0, 0, 0, 1'b0);
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL b2b_gap: got busy=%b expected 0", busy);
        else n_pass++;
        run_transform("b2b_second", 1'b1, 0, 0, 1'b0);
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL b2b_end: got busy=%b expected 0", busy);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_ntt();
        test_intt();
        test_stall();
        test_ignore_start();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
